// File: rtl/handshake_sender.sv
// Source end of the valid/ready handshake: streams a preloaded DEPTH-entry buffer
// once per start, with a source-side throttle (valid_test) for stall testing.
module handshake_sender #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  valid_test,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sent_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    // Buffer is only writable while idle so a run always sees a frozen image.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!valid_q) begin
                    if (valid_test) begin
                        valid_d = 1'b1;
                        data_d  = mem[idx_q[ADDR_WIDTH-1:0]];
                    end
                end else if (ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_inc;
                        // Back-to-back: prefetch the next word on the same edge.
                        if (valid_test) begin
                            data_d = mem[idx_inc[ADDR_WIDTH-1:0]];
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = cnt_q;

endmodule

// File: tb/tb_handshake_sender.sv
// Bench for handshake_sender: a word-queue scoreboard plus handshake protocol rules,
// driven by directed sequences and randomized ready/valid_test throttling.
module tb_handshake_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       valid_test;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [4:0] sent_count;

    handshake_sender #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .valid_test (valid_test),
        .valid      (valid),
        .ready      (ready),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: buffer image, queue of words still owed in this run.
    logic [7:0] model_mem [16];
    logic [7:0] exp_q [$];
    bit         sending = 0;
    bit         in_done = 0;
    int         xfers   = 0;
    int         done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a negedge, drives inputs, predicts and checks the next negedge.
    task automatic step(input bit rdy, input bit vt, input bit st = 0, input bit we = 0,
                        input logic [3:0] wa = 4'd0, input logic [7:0] wd = 8'd0);
        bit         pv;
        bit         xfer;
        bit         idle;
        bit         last;
        bit         exp_valid;
        bit         new_sending;
        logic [7:0] pd;
        ready = rdy; valid_test = vt; start = st; wr_en = we; wr_addr = wa; wr_data = wd;
        pv   = valid;
        pd   = data;
        xfer = pv && rdy;
        idle = !sending && !in_done;
        last = 1'b0;
        #1;
        check("valid_vs_ready_comb", valid, pv);
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("extra_transfer", 1, 0);
            end else begin
                check("xfer_data", data, exp_q.pop_front());
            end
            xfers++;
            last = (exp_q.size() == 0);
        end
        if (idle && we) model_mem[wa] = wd;
        @(negedge clk);
        exp_valid = sending && (pv ? (!xfer || (vt && !last)) : vt);
        new_sending = sending && !last;
        if (idle && st) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) exp_q.push_back(model_mem[i]);
            xfers = 0;
            new_sending = 1'b1;
        end
        in_done = sending && last;
        sending = new_sending;
        check("valid", valid, exp_valid);
        if (pv && !xfer) check("data_hold", data, pd);
        check("done", done, in_done);
        check("busy", busy, sending || in_done);
        check("sent_count", sent_count, xfers);
        if (done) done_seen++;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run_to_idle(input int mode);
        int n = 0;
        bit rdy;
        bit vt;
        while ((sending || in_done) && n < 600) begin
            case (mode)
                0, 3: begin rdy = 1'b1; vt = 1'b1; end
                1: begin rdy = 1'b1; vt = (n % 3 == 0); end
                default: begin rdy = 1'($urandom_range(1)); vt = ($urandom_range(99) < 70); end
            endcase
            if (mode == 3 && n % 4 == 1) step(rdy, vt, 1'b1, 1'b1, 4'd0, 8'hFF);
            else step(rdy, vt);
            n++;
        end
        check("run_finished", 32'(sending || in_done), 0);
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), rnd ? 8'($urandom) : 8'(8'h10 + i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sent_count"}, sent_count, 0);
        check({tag, "_data"}, data, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; valid_test = 1'b0; ready = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 'x;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: full-speed run
        preload(1'b0);
        step(1'b0, 1'b0, 1'b1);
        done_seen = 0;
        run_to_idle(0);
        check("t1_sent_count", sent_count, 16);
        check("t1_done_pulses", done_seen, 1);

        // 2: sink stall with valid already up
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2));
        check("t2_stall_data", data, 8'h10);
        run_to_idle(0);

        // 3: throttled source 1,0,0 pattern
        step(1'b0, 1'b0, 1'b1);
        run_to_idle(1);
        check("t3_sent_count", sent_count, 16);

        // 4: start/write pulses mid-run are ignored, next run unchanged
        step(1'b0, 1'b0, 1'b1);
        run_to_idle(3);
        step(1'b0, 1'b0, 1'b1);
        run_to_idle(0);

        // 5: asynchronous reset after 5 transfers
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        check("t5_pre_count", sent_count, 5);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        sending = 0; in_done = 0; xfers = 0; exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("t5_restart_data", data, 8'h10);
        run_to_idle(0);

        // 6: three back-to-back random runs over random buffer images
        done_seen = 0;
        for (int r = 0; r < 3; r++) begin
            preload(1'b1);
            step(1'b0, 1'b0, 1'b1);
            run_to_idle(2);
        end
        check("t6_done_pulses", done_seen, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
